// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes (E/M/W) and derives D-stage stall and bypass selects.
// Optional HAZARD_STALL_CNT_EN adds a 32-bit stall cycle counter output.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int TW     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [TW-1:0]     tuse_rs_d,
  input  logic [TW-1:0]     tuse_rt_d,
  input  logic              regwrite_d,
  input  logic [REG_AW-1:0] a3_d,
  input  logic [TW-1:0]     tnew_d,
  output logic              stall,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt,
  output logic              wr_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] a3;
    logic [TW-1:0]     tnew;
  } slot_t;
  slot_t e_q, m_q, w_q, e_d, m_d, w_d;
  logic [1:0]    rs_sel, rt_sel;
  logic [TW-1:0] rs_tn, rt_tn;
  function automatic logic [TW-1:0] sat0(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
  // Youngest matching slot wins: 1=E, 2=M, 3=W, 0=none.
  function automatic logic [1:0] pick(input logic v, input logic [REG_AW-1:0] src,
                                      input slot_t e, input slot_t m, input slot_t w);
    if (!v || src == '0) return 2'd0;
    return (e.valid && e.a3 == src) ? 2'd1 :
           (m.valid && m.a3 == src) ? 2'd2 :
           (w.valid && w.a3 == src) ? 2'd3 : 2'd0;
  endfunction
  always_comb begin
    rs_sel  = pick(valid_d, rs_d, e_q, m_q, w_q);
    rt_sel  = pick(valid_d, rt_d, e_q, m_q, w_q);
    rs_tn   = (rs_sel == 2'd1) ? e_q.tnew : (rs_sel == 2'd2) ? m_q.tnew : w_q.tnew;
    rt_tn   = (rt_sel == 2'd1) ? e_q.tnew : (rt_sel == 2'd2) ? m_q.tnew : w_q.tnew;
    stall   = ((rs_sel != 2'd0) && (rs_tn > tuse_rs_d)) ||
              ((rt_sel != 2'd0) && (rt_tn > tuse_rt_d));
    fwd_rs  = ((rs_sel != 2'd0) && (rs_tn == '0)) ? rs_sel : 2'd0;
    fwd_rt  = ((rt_sel != 2'd0) && (rt_tn == '0)) ? rt_sel : 2'd0;
    wr_busy = e_q.valid | m_q.valid | w_q.valid;
  end
  always_comb begin
    e_d = stall ? slot_t'('0) :
          slot_t'{valid: valid_d & regwrite_d & (a3_d != '0), a3: a3_d, tnew: tnew_d};
    m_d = slot_t'{valid: e_q.valid, a3: e_q.a3, tnew: sat0(e_q.tnew)};
    w_d = slot_t'{valid: m_q.valid, a3: m_q.a3, tnew: sat0(m_q.tnew)};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = stall ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stall_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard bench for hazard_scoreboard (stall/bypass/busy, optional counter).
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_d = 1'b0, regwrite_d = 1'b0;
  logic [4:0] rs_d = '0, rt_d = '0, a3_d = '0;
  logic [1:0] tuse_rs_d = '0, tuse_rt_d = '0, tnew_d = '0;
  logic       stall, wr_busy;
  logic [1:0] fwd_rs, fwd_rt;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int compared = 0;
  int mismatched = 0;
  typedef struct packed {
    logic       s;
    logic [1:0] fs;
    logic [1:0] ft;
    logic       b;
  } exp_t;
  exp_t exp_q[$];

  hazard_scoreboard #(.REG_AW(5), .TW(2)) dut (
    .clk(clk), .reset(rst), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .regwrite_d(regwrite_d),
    .a3_d(a3_d), .tnew_d(tnew_d), .stall(stall), .fwd_rs(fwd_rs),
    .fwd_rt(fwd_rt), .wr_busy(wr_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    chk({tag, "_stall"}, 32'(stall), 32'(e.s));
    chk({tag, "_fwd_rs"}, 32'(fwd_rs), 32'(e.fs));
    chk({tag, "_fwd_rt"}, 32'(fwd_rt), 32'(e.ft));
    chk({tag, "_busy"}, 32'(wr_busy), 32'(e.b));
  endtask

  task automatic step(input string tag, input logic v, input logic rw, input logic [4:0] a3,
                      input logic [1:0] tn, input logic [4:0] rs, input logic [1:0] urs,
                      input logic [4:0] rt, input logic [1:0] urt, input logic es,
                      input logic [1:0] efs, input logic [1:0] eft, input logic eb);
    @(negedge clk);
    valid_d = v; regwrite_d = rw; a3_d = a3; tnew_d = tn;
    rs_d = rs; tuse_rs_d = urs; rt_d = rt; tuse_rt_d = urt;
    exp_q.push_back('{s: es, fs: efs, ft: eft, b: eb});
    #1 check_out(tag);
  endtask

  initial begin
    #1;
    exp_q.push_back('0);
    check_out("reset");
`ifdef HAZARD_STALL_CNT_EN
    chk("reset_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk) rst = 1'b0;
    step("alu_wr",    1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("alu_e",     1, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1);
    step("alu_m",     1, 0, 0, 0, 8, 1, 0, 0, 0, 2, 0, 1);
    step("alu_w",     1, 0, 0, 0, 8, 1, 0, 0, 0, 3, 0, 1);
    step("alu_drain", 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0);
    step("lu_wr",     1, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_s1",     1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 1);
    step("lu_s2",     1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 1);
    step("lu_fwd",    1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 3, 1);
    step("lu_drain",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r0_wr",     1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r0_use",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sh_wr1",    1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sh_wr2",    1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("sh_e",      1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1);
    step("sh_m",      1, 0, 0, 0, 5, 1, 0, 0, 0, 2, 0, 1);
    step("sh_d1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("sh_d2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("bo_wr",     1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("bo_use",    1, 0, 0, 0, 3, 0, 3, 0, 0, 1, 1, 1);
    step("bo_d1",     0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1);
    step("bo_d2",     0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 1);
    step("bo_d3",     0, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0);
    step("mr_wr",     1, 1, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    step("mr_stall",  1, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0, 1);
    rst = 1'b1;
    exp_q.push_back('0);
    #1 check_out("mr_async");
`ifdef HAZARD_STALL_CNT_EN
    chk("mr_cnt", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_q.push_back('0);
    #1 check_out("mr_release");
    for (int i = 0; i < 3; i++) begin
      step("cn_wr",    1, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      step("cn_s1",    1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 1);
      step("cn_s2",    1, 0, 0, 0, 0, 0, 9, 0, 1, 0, 0, 1);
      step("cn_fwd",   1, 0, 0, 0, 0, 0, 9, 0, 0, 0, 3, 1);
      step("cn_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
`ifdef HAZARD_STALL_CNT_EN
    chk("cnt_six", stall_cnt, 32'd6);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
